// File: rtl/itag_ctl.sv
// Instruction-cache tag store sequencer: invalidates all tags after reset and
// on flush, compares fetch addresses against the tag RAM one cycle after
// acceptance, and on a miss requests a line fill and writes the new valid tag.
module itag_ctl #(
  parameter int NL  = 128,
  parameter int LSS = 7,
  parameter int LSH = LSS + 4,
  parameter int PSL = LSH + 1,
  parameter int TS  = 2 + (32 - PSL)
) (
  input  logic          nGCLK,
  input  logic          nRESET,
  input  logic          lookup_valid,
  input  logic [31:0]   lookup_addr,
  output logic          ready,
  output logic          hit,
  output logic          miss,
  output logic          fill_req,
  output logic [31:0]   fill_addr,
  input  logic          fill_done,
  input  logic          flush_req,
  output logic          flush_busy,
  output logic [LSS-1:0] tag_read_sel,
  input  logic [TS-1:0] tag_rd_data,
  output logic [LSS-1:0] tag_write_sel,
  output logic [TS-1:0] tag_write_port,
  output logic          tag_wr_ena
);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_SWEEP     = 3'd1,
    ST_IDLE      = 3'd2,
    ST_MISS_WAIT = 3'd3,
    ST_TAG_WR    = 3'd4
  } state_e;

  localparam logic [LSS-1:0] LAST_LINE = LSS'(NL - 1);
  localparam logic [LSS-1:0] ONE_LINE  = {{(LSS-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [LSS-1:0]  cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            cmp_valid_q, cmp_valid_d;
  logic [31:5]     reg_addr_q, reg_addr_d;
  logic            fill_req_q, fill_req_d;
  logic [31:5]     fill_addr_q, fill_addr_d;

  logic            match_s;
  logic            cmp_miss_s;
  logic            ready_s;
  logic            accept_s;
  logic            unused_bits_s;

  // Byte offset and the dirty bit play no part in tag matching.
  assign unused_bits_s = ^{lookup_addr[4:0], tag_rd_data[TS-2]};

  // Compare stage: valid tag whose page equals the registered fetch page.
  always_comb begin
    match_s    = tag_rd_data[TS-1] & (tag_rd_data[TS-3:0] == reg_addr_q[31:PSL]);
    cmp_miss_s = cmp_valid_q & ~match_s;
    ready_s    = (state_q == ST_IDLE) & ~flush_req & ~pend_q & ~cmp_miss_s;
    accept_s   = lookup_valid & ready_s;
  end

  // Capture an accepted lookup so its tag can be compared next cycle.
  always_comb begin
    cmp_valid_d = accept_s;
    if (accept_s) begin
      reg_addr_d = lookup_addr[31:5];
    end else begin
      reg_addr_d = reg_addr_q;
    end
  end

  // Next-state logic for the sweep / lookup / fill sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    fill_req_d  = fill_req_q;
    fill_addr_d = fill_addr_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_SWEEP;
        cnt_d   = {LSS{1'b0}};
      end
      ST_SWEEP: begin
        if (cnt_q == LAST_LINE) begin
          // A flush seen during this sweep buys exactly one more full sweep.
          cnt_d  = {LSS{1'b0}};
          pend_d = 1'b0;
          if (pend_q | flush_req) begin
            state_d = ST_SWEEP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d  = cnt_q + ONE_LINE;
          pend_d = pend_q | flush_req;
        end
      end
      ST_IDLE: begin
        if (flush_req) begin
          // Flush wins over a concurrent miss: that miss is dropped unfilled.
          state_d = ST_SWEEP;
          cnt_d   = {LSS{1'b0}};
        end else if (cmp_miss_s) begin
          state_d     = ST_MISS_WAIT;
          fill_req_d  = 1'b1;
          fill_addr_d = reg_addr_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MISS_WAIT: begin
        pend_d = pend_q | flush_req;
        if (fill_done) begin
          state_d    = ST_TAG_WR;
          fill_req_d = 1'b0;
        end else begin
          state_d = ST_MISS_WAIT;
        end
      end
      ST_TAG_WR: begin
        pend_d = 1'b0;
        cnt_d  = {LSS{1'b0}};
        if (pend_q | flush_req) begin
          state_d = ST_SWEEP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_INIT;
        cnt_d      = {LSS{1'b0}};
        pend_d     = 1'b0;
        fill_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any sweep or fill.
  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= ST_INIT;
      cnt_q       <= {LSS{1'b0}};
      pend_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      reg_addr_q  <= 27'd0;
      fill_req_q  <= 1'b0;
      fill_addr_q <= 27'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      cmp_valid_q <= cmp_valid_d;
      reg_addr_q  <= reg_addr_d;
      fill_req_q  <= fill_req_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  // Output decode from registered state and the compare stage.
  always_comb begin
    ready        = ready_s;
    hit          = cmp_valid_q & match_s;
    miss         = cmp_miss_s;
    fill_req     = fill_req_q;
    fill_addr    = {fill_addr_q, 5'b00000};
    flush_busy   = (state_q == ST_SWEEP) | pend_q | (state_q == ST_INIT);
    tag_read_sel = lookup_addr[LSH:5];
    if (state_q == ST_TAG_WR) begin
      tag_wr_ena     = 1'b1;
      tag_write_sel  = reg_addr_q[LSH:5];
      tag_write_port = {1'b1, 1'b0, reg_addr_q[31:PSL]};
    end else if (state_q == ST_SWEEP) begin
      tag_wr_ena     = 1'b1;
      tag_write_sel  = cnt_q;
      tag_write_port = {TS{1'b0}};
    end else begin
      tag_wr_ena     = 1'b0;
      tag_write_sel  = cnt_q;
      tag_write_port = {TS{1'b0}};
    end
  end

endmodule

// File: tb/tb_itag_ctl.sv
// Self-checking bench for itag_ctl: the bench owns the tag RAM and keeps an
// abstract picture of which page each line should hold.
module tb_itag_ctl;

  localparam int NL  = 128;
  localparam int LSS = 7;
  localparam int PSL = 12;
  localparam int TS  = 22;

  logic           nGCLK;
  logic           nRESET;
  logic           lookup_valid;
  logic [31:0]    lookup_addr;
  logic           ready, hit, miss, fill_req, flush_busy, tag_wr_ena;
  logic [31:0]    fill_addr;
  logic           fill_done, flush_req;
  logic [LSS-1:0] tag_read_sel, tag_write_sel;
  logic [TS-1:0]  tag_rd_data, tag_write_port;

  itag_ctl dut (
    .nGCLK(nGCLK), .nRESET(nRESET),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
    .ready(ready), .hit(hit), .miss(miss),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_done(fill_done),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .tag_read_sel(tag_read_sel), .tag_rd_data(tag_rd_data),
    .tag_write_sel(tag_write_sel), .tag_write_port(tag_write_port),
    .tag_wr_ena(tag_wr_ena)
  );

  initial nGCLK = 1'b0;
  always #5 nGCLK = ~nGCLK;

  // Tag RAM: one write port, one synchronous read port.
  logic [TS-1:0] ram [NL];
  always @(posedge nGCLK) begin
    if (tag_wr_ena === 1'b1) ram[tag_write_sel] <= tag_write_port;
    tag_rd_data <= ram[tag_read_sel];
  end

  // Reference picture of the cache: valid flag and page per line.
  bit          ref_v  [NL];
  logic [19:0] ref_pg [NL];
  logic [31:0] hist [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge nGCLK);
    #1;
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) % NL);
  endfunction

  function automatic logic [19:0] page_of(input logic [31:0] a);
    return 20'(a >> PSL);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return ref_v[line_of(a)] && (ref_pg[line_of(a)] == page_of(a));
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [19:0] pages [4];
    int lines [4];
    pages[0] = 20'h00000; pages[1] = 20'h00001; pages[2] = 20'h00002; pages[3] = 20'h80001;
    lines[0] = 0; lines[1] = 5; lines[2] = 'h52; lines[3] = NL - 1;
    return {pages[$urandom_range(0, 3)], 7'(lines[$urandom_range(0, 3)]), 5'($urandom)};
  endfunction

  // Current cycle is sweep cycle 0; inject >= 0 pulses flush_req in that sweep cycle.
  task automatic sweep(input int inject);
    int total = (inject >= 0) ? 2 * NL : NL;
    int bad = 0;
    for (int i = 0; i < total; i++) begin
      flush_req = (i == inject);
      #1;
      if (tag_wr_ena !== 1'b1 || int'(tag_write_sel) != (i % NL) || tag_write_port !== '0 ||
          flush_busy !== 1'b1 || ready !== 1'b0 || fill_req !== 1'b0) bad++;
      tick();
    end
    flush_req = 1'b0;
    #1;
    check_eq("sweep_cycles", 32'(bad), 32'd0);
    check_eq("sweep_end_wr", 32'(tag_wr_ena), 32'd0);
    check_eq("sweep_end_busy", 32'(flush_busy), 32'd0);
    check_eq("sweep_end_ready", 32'(ready), 32'd1);
    for (int i = 0; i < NL; i++) ref_v[i] = 1'b0;
  endtask

  // One lookup from IDLE, including the fill if the model predicts a miss.
  task automatic do_lookup(input logic [31:0] a, input bit hold2, input bit flush_mw);
    bit exp_hit = model_hit(a);
    int n, bad;
    lookup_valid = 1'b1; lookup_addr = a; fill_done = 1'($urandom);
    #1 check_eq("acc_ready", 32'(ready), 32'd1);
    tick();
    lookup_valid = hold2 && !exp_hit; lookup_addr = $urandom; fill_done = 1'($urandom);
    #1;
    check_eq("hit", 32'(hit), 32'(exp_hit));
    check_eq("miss", 32'(miss), 32'(!exp_hit));
    if (!exp_hit) check_eq("miss_ready", 32'(ready), 32'd0);
    tick();
    lookup_valid = 1'b0; fill_done = 1'b0;
    if (!exp_hit) begin
      flush_req = flush_mw;
      #1;
      check_eq("fill_req", 32'(fill_req), 32'd1);
      check_eq("fill_addr", fill_addr, a & 32'hFFFF_FFE0);
      check_eq("mw_no_cmp", 32'({hit, miss}), 32'd0);
      check_eq("mw_no_wr", 32'(tag_wr_ena), 32'd0);
      n = $urandom_range(0, 4);
      bad = 0;
      for (int i = 0; i < n; i++) begin
        tick();
        flush_req = 1'b0;
        #1;
        if (fill_req !== 1'b1 || tag_wr_ena !== 1'b0 || (flush_mw && flush_busy !== 1'b1)) bad++;
      end
      check_eq("mw_hold", 32'(bad), 32'd0);
      fill_done = 1'b1;
      tick();
      fill_done = 1'b0; flush_req = 1'b0;
      #1;
      check_eq("tw_fill_req", 32'(fill_req), 32'd0);
      check_eq("tw_wr_ena", 32'(tag_wr_ena), 32'd1);
      check_eq("tw_sel", 32'(tag_write_sel), 32'(line_of(a)));
      check_eq("tw_data", 32'(tag_write_port), (32'd1 << (TS - 1)) | 32'(page_of(a)));
      if (flush_mw) check_eq("tw_busy", 32'(flush_busy), 32'd1);
      ref_v[line_of(a)] = 1'b1;
      ref_pg[line_of(a)] = page_of(a);
      hist.push_back(a);
      tick();
      if (flush_mw) begin
        sweep(-1);
      end else begin
        check_eq("post_fill_idle", 32'({hit, miss, tag_wr_ena, ready}), 32'd1);
      end
    end
  endtask

  // Back-to-back lookups of lines the model says are resident.
  task automatic run_stream(input int n);
    logic [31:0] cand [$];
    logic [31:0] a;
    foreach (hist[i]) if (model_hit(hist[i])) cand.push_back(hist[i]);
    if (cand.size() == 0) return;
    for (int k = 0; k < n; k++) begin
      a = cand[$urandom_range(0, cand.size() - 1)];
      lookup_valid = 1'b1;
      lookup_addr = (a & 32'hFFFF_FFE0) | ($urandom & 32'h1F);
      #1 check_eq("stream_ready", 32'(ready), 32'd1);
      if (k > 0) check_eq("stream_hit", 32'({hit, miss}), 32'd2);
      tick();
    end
    lookup_valid = 1'b0;
    #1 check_eq("stream_last_hit", 32'({hit, miss}), 32'd2);
    tick();
  endtask

  // Lookup accepted, then flush on the very next cycle: compare reported, no fill.
  task automatic accept_then_flush(input logic [31:0] a);
    bit exp_hit = model_hit(a);
    lookup_valid = 1'b1; lookup_addr = a;
    #1 check_eq("atf_ready", 32'(ready), 32'd1);
    tick();
    lookup_valid = 1'b0; flush_req = 1'b1;
    #1 check_eq("atf_result", 32'({hit, miss}), exp_hit ? 32'd2 : 32'd1);
    tick();
    flush_req = 1'b0;
    #1 check_eq("atf_no_fill", 32'(fill_req), 32'd0);
    sweep(-1);
  endtask

  task automatic idle_flush(input int inject);
    flush_req = 1'b1;
    #1 check_eq("flush_ready", 32'(ready), 32'd0);
    tick();
    flush_req = 1'b0;
    sweep(inject);
  endtask

  initial begin
    for (int i = 0; i < NL; i++) ram[i] = TS'($urandom) | (TS'(1) << (TS - 1));
    nRESET = 1'b0; lookup_valid = 1'b0; lookup_addr = 32'd0;
    fill_done = 1'b0; flush_req = 1'b0;
    repeat (3) tick();
    check_eq("rst_outs", 32'({ready, hit, miss, fill_req, tag_wr_ena}), 32'd0);
    check_eq("rst_fill_addr", fill_addr, 32'd0);
    check_eq("rst_busy", 32'(flush_busy), 32'd1);
    nRESET = 1'b1;
    #1 check_eq("init_wr", 32'(tag_wr_ena), 32'd0);
    tick();
    sweep(-1);

    // Directed: fill and re-hit, alias on the same line, streaming hits.
    do_lookup(32'h0000_1A40, 1'b0, 1'b0);
    do_lookup(32'h0000_1A40, 1'b0, 1'b0);
    do_lookup(32'h0000_2A40, 1'b0, 1'b0);
    do_lookup(32'h0000_1A40, 1'b0, 1'b0);
    do_lookup(32'h0000_3000, 1'b0, 1'b0);
    run_stream(6);
    do_lookup(32'h0000_4A40, 1'b1, 1'b0);
    do_lookup(32'h0000_5000, 1'b0, 1'b1);
    do_lookup(32'h0000_5000, 1'b0, 1'b0);
    idle_flush(NL - 1);

    // Randomized operation mix.
    for (int it = 0; it < 50; it++) begin
      case ($urandom_range(0, 9))
        0: idle_flush(($urandom_range(0, 2) == 0) ? $urandom_range(0, NL - 1) : -1);
        1: accept_then_flush(rand_addr());
        2, 3: run_stream($urandom_range(2, 6));
        default: do_lookup(rand_addr(), 1'($urandom), $urandom_range(0, 5) == 0);
      endcase
    end

    // Reset in the middle of a fill.
    idle_flush(-1);
    lookup_valid = 1'b1; lookup_addr = 32'h0000_7120;
    tick();
    lookup_valid = 1'b0;
    #1 check_eq("rm_miss", 32'(miss), 32'd1);
    tick();
    #1 check_eq("rm_fill_req", 32'(fill_req), 32'd1);
    #1 nRESET = 1'b0;
    #1;
    check_eq("rm_async_fill", 32'(fill_req), 32'd0);
    check_eq("rm_outs", 32'({ready, hit, miss, tag_wr_ena}), 32'd0);
    check_eq("rm_fill_addr", fill_addr, 32'd0);
    check_eq("rm_busy", 32'(flush_busy), 32'd1);
    fill_done = 1'b1;
    tick();
    tick();
    fill_done = 1'b0;
    nRESET = 1'b1;
    #1 check_eq("rm_init_wr", 32'(tag_wr_ena), 32'd0);
    tick();
    sweep(-1);
    do_lookup(32'h0000_7120, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/itag_ctl.md
Name: itag_ctl

Overview:
Sequencing controller for the instruction-cache tag store (NL lines, 2-ported tag RAM with one read port and one write port, synchronous read). It invalidates every tag after reset and on flush. It looks up fetch addresses against the tag store and reports hit or miss. On a miss it requests a line fill from the bus interface and writes the new valid tag when the fill completes. It sits between the fetch unit, the BIU and the tag RAM.

Parameters:
NL, 128, number of cache lines
LSS, 7, line-select bits = log2(NL)
LSH, LSS+4, high bit of the line index in the address (line index = addr[LSH:5]; 32-byte lines)
PSL, LSH+1, low bit of the page tag
TS, 2+(32-PSL), tag width: bit TS-1 = V, bit TS-2 = D, bits [TS-3:0] = addr[31:PSL]

Ports:
nGCLK  in  1  clock; all state changes on rising edge
nRESET  in  1  asynchronous reset, active low
lookup_valid  in  1  fetch address presented
lookup_addr  in  32  fetch address
ready  out  1  lookup accepted this cycle if lookup_valid=1
hit  out  1  one-cycle pulse: accepted lookup hit
miss  out  1  one-cycle pulse: accepted lookup missed
fill_req  out  1  line fill request to BIU, level
fill_addr  out  32  line-aligned fill address {addr[31:5],5'b0}
fill_done  in  1  BIU pulse: line data written
flush_req  in  1  invalidate-all request pulse
flush_busy  out  1  sweep in progress or pending
tag_read_sel  out  LSS  tag RAM read line
tag_rd_data  in  TS  tag RAM read data, valid the cycle after tag_read_sel
tag_write_sel  out  LSS  tag RAM write line
tag_write_port  out  TS  tag RAM write data
tag_wr_ena  out  1  tag RAM write enable

Behaviour:
- Reset (nRESET=0, any state, including mid-fill or mid-sweep):
  - state=INIT, sweep counter=0, flush_pending=0, compare stage cleared.
  - Output values: ready=0, hit=0, miss=0, fill_req=0, fill_addr=0, tag_wr_ena=0, flush_busy=1.
  - A fill in progress is abandoned; the BIU is reset by the same nRESET.
- States: INIT, SWEEP, IDLE, MISS_WAIT, TAG_WR.
- INIT -> SWEEP on the first edge after reset release.
- SWEEP:
  - tag_wr_ena=1, tag_write_sel=counter, tag_write_port=0; counter increments each cycle.
  - When counter==NL-1 the state moves to IDLE and the counter wraps to 0.
  - Duration is exactly NL cycles; flush_busy=1 throughout.
- IDLE, lookup:
  - tag_read_sel = lookup_addr[LSH:5] combinationally.
  - ready = IDLE & ~flush_req & ~flush_pending & ~(cmp_valid & ~match).
  - On an accepted lookup (cycle N), the address is registered and cmp_valid=1 in cycle N+1.
  - In N+1: match = tag_rd_data[TS-1] & (tag_rd_data[TS-3:0]==reg_addr[31:PSL]). hit=match, miss=~match. D is ignored.
  - Back-to-back hits are sustained at one per cycle.
- Miss:
  - In the miss cycle, ready=0, so any lookup_valid in that cycle is not accepted.
  - Next state MISS_WAIT; fill_req=1 and fill_addr registered.
- MISS_WAIT: fill_req is held until fill_done. On fill_done, fill_req drops on the next edge and the state moves to TAG_WR.
- TAG_WR:
  - One cycle: tag_wr_ena=1, tag_write_sel=reg_addr[LSH:5], tag_write_port={1'b1,1'b0,reg_addr[31:PSL]}.
  - Then IDLE; the fetch unit re-presents the address and hits.
- Flush:
  - flush_req in IDLE (no miss pending): the state moves to SWEEP next edge.
  - A lookup accepted the cycle before still completes its compare; its miss, if any, is discarded (no fill).
  - flush_req in MISS_WAIT/TAG_WR/SWEEP sets flush_pending. The fill completes, including TAG_WR, then a full SWEEP runs.
  - flush_req during SWEEP restarts nothing; the pending flag causes one additional full sweep.
  - flush_busy = (state==SWEEP) | flush_pending | (state==INIT).
- fill_done outside MISS_WAIT is ignored.
- tag_wr_ena is never asserted in IDLE or MISS_WAIT.

Test Plan:
- Reset release -> tag_wr_ena high for exactly 128 cycles with tag_write_sel 0..127 and data 0; ready first high on edge 129; flush_busy low from then.
- Lookup 0x0000_1A40 after the sweep -> miss pulse next cycle; fill_req=1, fill_addr=0x0000_1A40. fill_done -> one write at line 0x52 with tag {1,0,20'h00001}. Re-lookup -> hit pulse.
- Two hit addresses on consecutive cycles -> hit pulses on consecutive cycles, ready held high; a miss followed by lookup_valid -> ready=0 in the miss cycle and the second lookup is not accepted.
- Same line index, different page (0x0000_1A40 filled, then 0x0000_2A40) -> miss; after its fill, 0x0000_1A40 misses.
- flush_req during MISS_WAIT -> fill completes, TAG_WR occurs, then a 128-cycle sweep; a subsequent lookup of the filled address misses.
- nRESET asserted mid-MISS_WAIT -> fill_req=0 immediately (asynchronous); after release, a full sweep and no TAG_WR.
